regfile_wb_arbiter: RTL

- Shares the register file's single write port between NUM_REQ write-back requesters, for example the ALU result path and the load path.
- Arbitration is round-robin with a valid/ready handshake.
- Drives registered wr_en/wr_addr/wr_data directly into the register file's regWrite/writeRegister/writeData inputs.
- Sits between the pipeline's write-back sources and the register file.

---
 rtl/mips_wb_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 38 +++
 rtl/regfile_wb_arbiter.sv | 91 +++++++++
 3 files changed

// File: rtl/mips_wb_pkg.sv
// Shared types and helpers for the register-file write-back path.
package mips_wb_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

  // Index of the set bit in a one-hot (or zero) vector of up to 8 requesters.
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] onehot);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (onehot[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first valid requester at or after rrPtr wins.
module rr_arbiter
  import mips_wb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned PTR_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PTR_W-1:0]   rrPtr,
  input  logic               flush,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grantIdx,
  output logic               anyGrant
);

  logic [PTR_W:0] pos;
  logic           found;

  // Walk the requesters cyclically from rrPtr; the extra pos bit absorbs the wrap.
  always_comb begin
    grant = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = {1'b0, rrPtr} + (PTR_W+1)'(k);
      if (pos >= (PTR_W+1)'(NUM_REQ)) pos = pos - (PTR_W+1)'(NUM_REQ);
      if (!found && valid[pos[PTR_W-1:0]]) begin
        grant[pos[PTR_W-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
    if (flush) grant = '0;
  end

  assign anyGrant = |grant;
  assign grantIdx = PTR_W'(onehot_to_idx(8'(grant)));

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin share of the register file write port among NUM_REQ write-back sources.
// Optional WB_STATS_EN adds a saturating contention counter (conflict_cnt, stats_clr).
module regfile_wb_arbiter
  import mips_wb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = REG_ADDR_W,
  parameter int unsigned DATA_W  = REG_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  input  logic [ADDR_W-1:0]         probe_addr,
  output logic                      busy_addr_hit
`ifdef WB_STATS_EN
  ,
  input  logic                      stats_clr,
  output logic [15:0]               conflict_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]  rrPtr;
  logic [PTR_W-1:0]  grantIdx;
  logic              anyGrant;
  logic [ADDR_W-1:0] reqAddrArr [NUM_REQ];
  logic [DATA_W-1:0] reqDataArr [NUM_REQ];
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selData;

  for (genvar i = 0; i < NUM_REQ; i++) begin : gUnpack
    assign reqAddrArr[i] = req_addr[i*ADDR_W +: ADDR_W];
    assign reqDataArr[i] = req_data[i*DATA_W +: DATA_W];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) uArb (
    .valid    (req_valid),
    .rrPtr    (rrPtr),
    .flush    (flush),
    .grant    (req_ready),
    .grantIdx (grantIdx),
    .anyGrant (anyGrant)
  );

  assign selAddr = reqAddrArr[grantIdx];
  assign selData = reqDataArr[grantIdx];

  // Stage register and pointer; r0 writes still advance the pointer but never assert wr_en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      rrPtr   <= '0;
    end else if (anyGrant) begin
      wr_en   <= (selAddr != ADDR_W'(REG_ZERO));
      wr_addr <= selAddr;
      wr_data <= selData;
      rrPtr   <= (grantIdx == PTR_W'(NUM_REQ - 1)) ? '0 : grantIdx + PTR_W'(1);
    end else begin
      wr_en <= 1'b0;
    end
  end

  assign busy_addr_hit = wr_en && (wr_addr == probe_addr) && (probe_addr != ADDR_W'(REG_ZERO));

`ifdef WB_STATS_EN
  logic multiValid;

  assign multiValid = |(req_valid & (req_valid - NUM_REQ'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if (stats_clr) begin
      conflict_cnt <= '0;
    end else if (multiValid && !flush && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif

endmodule
